// File: rtl/many_functions_decoder.sv
// rtl/many_functions_decoder.sv - iterative decoder for the many_functions encodings (optional err port: MANY_FUNCTIONS_DECODER_ERR_EN)
module many_functions_decoder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef MANY_FUNCTIONS_DECODER_ERR_EN
    output logic             err,
`endif
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y
);

    localparam int MAXN = (WIDTH > DEPTH) ? WIDTH : DEPTH;
    localparam int CW   = $clog2(MAXN + 1);
    localparam int IW   = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    idx;
    logic             noshift;
    logic             accept;
    logic             clamped;
    logic [CW-1:0]    shift_amt;
    logic [CW-1:0]    n_load;
    logic [IW-1:0]    rev_idx;
    logic [IW-1:0]    lo_idx;
    logic [IW-1:0]    hi_idx;
`ifdef MANY_FUNCTIONS_DECODER_ERR_EN
    logic             clamped_q;
`endif

    assign accept = in_valid && in_ready;

    // Clamp the requested shift and work out the step count for the incoming request.
    always_comb begin
        clamped   = in_b > DEPTH_W;
        shift_amt = clamped ? CW'(DEPTH) : CW'(in_b);
        n_load    = CW'(1);
        case (sel)
            2'b00:   n_load = CW'(WIDTH);
            2'b01:   n_load = CW'(WIDTH / 2);
            2'b10:   n_load = (shift_amt == '0) ? CW'(1) : shift_amt;
            default: n_load = CW'(1);
        endcase
    end

    // Bit positions touched by the reverse and de-interleave steps.
    always_comb begin
        rev_idx = IW'(WIDTH - 1) - idx;
        lo_idx  = {idx[IW-2:0], 1'b0};
        hi_idx  = {idx[IW-2:0], 1'b1};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = BUSY;
            end
            BUSY: begin
                if (cnt == CW'(1)) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture on accept, then one decode step per BUSY cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode    <= 2'b00;
            a       <= '0;
            b       <= '0;
            cnt     <= '0;
            idx     <= '0;
            noshift <= 1'b0;
            out_x   <= '0;
            out_y   <= '0;
        end else if (accept) begin
            mode    <= sel;
            a       <= in_a;
            b       <= in_b;
            cnt     <= n_load;
            idx     <= '0;
            noshift <= (shift_amt == '0);
            out_x   <= '0;
            out_y   <= '0;
        end else if (state == BUSY) begin
            cnt <= cnt - CW'(1);
            idx <= idx + IW'(1);
            case (mode)
                2'b00: out_x[idx] <= a[rev_idx];
                2'b01: begin
                    out_x[idx] <= a[lo_idx];
                    out_y[idx] <= a[hi_idx];
                end
                2'b10: begin
                    if (noshift) begin
                        out_x <= a;
                    end else begin
                        a     <= a >> 1;
                        out_x <= a >> 1;
                    end
                end
                default: begin
                    out_x <= a;
                    out_y <= b - a;
                end
            endcase
        end
    end

`ifdef MANY_FUNCTIONS_DECODER_ERR_EN
    // err flags a clamped shift or a set bit falling off the bottom of the shifter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err       <= 1'b0;
            clamped_q <= 1'b0;
        end else if (accept) begin
            err       <= 1'b0;
            clamped_q <= clamped && (sel == 2'b10);
        end else if (state == BUSY && mode == 2'b10) begin
            err <= err | clamped_q | (!noshift && a[0]);
        end
    end
`endif

endmodule

// File: tb/tb_many_functions_decoder.sv
// tb/tb_many_functions_decoder.sv - directed vector bench for many_functions_decoder
module tb_many_functions_decoder;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       sel = 2'b00;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_x;
    logic [WIDTH-1:0] out_y;
    logic             err;

    many_functions_decoder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef MANY_FUNCTIONS_DECODER_ERR_EN
        .err(err),
`endif
        .out_x(out_x), .out_y(out_y)
    );

`ifndef MANY_FUNCTIONS_DECODER_ERR_EN
    assign err = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       s;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int               n;
        logic [WIDTH-1:0] ex;
        logic [WIDTH-1:0] ey;
        logic             eerr;
    } vec_t;

    vec_t vecs[9];
    int   compared = 0;
    int   mismatched = 0;
    int   lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        in_valid = 1'b1; sel = s; in_a = a; in_b = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0; sel = ~s; in_a = ~a; in_b = ~b;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{2'b00, 8'h01, 8'h00, 8, 8'h80, 8'h00, 1'b0};
        vecs[1] = '{2'b00, 8'hB4, 8'h5A, 8, 8'h2D, 8'h00, 1'b0};
        vecs[2] = '{2'b01, 8'h96, 8'hFF, 4, 8'h06, 8'h09, 1'b0};
        vecs[3] = '{2'b10, 8'hA0, 8'h03, 3, 8'h14, 8'h00, 1'b0};
        vecs[4] = '{2'b10, 8'hA0, 8'h00, 1, 8'hA0, 8'h00, 1'b0};
        vecs[5] = '{2'b10, 8'hA0, 8'h07, 4, 8'h0A, 8'h00, 1'b1};
        vecs[6] = '{2'b10, 8'h0F, 8'h02, 2, 8'h03, 8'h00, 1'b1};
        vecs[7] = '{2'b11, 8'h10, 8'h05, 1, 8'h10, 8'hF5, 1'b0};
        vecs[8] = '{2'b11, 8'h03, 8'h03, 1, 8'h03, 8'h00, 1'b0};

        #2;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_x", 32'(out_x), 32'd0);
        chk("reset_out_y", 32'(out_y), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            start_op(vecs[i].s, vecs[i].a, vecs[i].b);
            wait_done(lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].n));
            chk($sformatf("vec%0d_out_x", i), 32'(out_x), 32'(vecs[i].ex));
            chk($sformatf("vec%0d_out_y", i), 32'(out_y), 32'(vecs[i].ey));
`ifdef MANY_FUNCTIONS_DECODER_ERR_EN
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].eerr));
`endif
            consume();
            chk($sformatf("vec%0d_back_idle", i), 32'(in_ready), 32'd1);
        end

        // Backpressure: result held while out_ready low, in_valid ignored.
        start_op(2'b11, 8'h10, 8'h05);
        wait_done(lat);
        chk("bp_latency", 32'(lat), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1; sel = 2'b00; in_a = 8'hFF; in_b = 8'hFF;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
            chk($sformatf("bp%0d_out_x", c), 32'(out_x), 32'h10);
            chk($sformatf("bp%0d_out_y", c), 32'(out_y), 32'hF5);
        end
        consume();
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_retain_out_x", 32'(out_x), 32'h10);
        chk("bp_retain_out_y", 32'(out_y), 32'hF5);
        @(posedge clk);
        #1;
        chk("bp_no_ghost_accept", 32'(in_ready), 32'd1);

        // Asynchronous reset three cycles into a mode-00 operation.
        start_op(2'b00, 8'hFF, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_op_partial_x", 32'(out_x), 32'h07);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_out_x", 32'(out_x), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        start_op(2'b01, 8'h96, 8'h00);
        wait_done(lat);
        chk("post_rst_latency", 32'(lat), 32'd4);
        chk("post_rst_out_x", 32'(out_x), 32'h06);
        chk("post_rst_out_y", 32'(out_y), 32'h09);
        consume();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
